// File: rtl/spi_regfile_pkg.sv
// rtl/spi_regfile_pkg.sv - shared types, constants and helpers for the SPI register file
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with level and single-cycle edge outputs
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_regfile_periph.sv
// rtl/spi_regfile_periph.sv - SPI mode-0 peripheral giving read/write access to a register bank
// All SPI pins are oversampled in the clk domain; nothing is clocked by sclk.
module spi_regfile_periph
  import spi_regfile_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cs_n,
  input  logic                       sclk,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic [NUM_REGS-1:0]        wr_stb,
  output logic                       frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  logic cs_lvl, cs_rise, sclk_rise, sclk_fall, copi_lvl;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .level(cs_lvl), .rise(cs_rise), .fall()
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .level(), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(copi), .level(copi_lvl), .rise(), .fall()
  );

  state_e             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] rx_sr;
  logic [DATA_W-1:0]  tx_sr;
  logic               rd_phase;
  logic [DATA_W-1:0]  mid_rd;
  logic [NUM_REGS-1:0] end_hit;

  // mid_rd decodes the address just received; end_hit decodes the address of a complete frame
  always_comb begin
    mid_rd  = '0;
    end_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rx_sr[ADDR_W-1:0] == ADDR_W'(i)) mid_rd = regs[i*DATA_W +: DATA_W];
      end_hit[i] = (rx_sr[FRAME_W-2 -: ADDR_W] == ADDR_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      rd_phase  <= 1'b0;
      regs      <= '0;
      wr_stb    <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_stb    <= '0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!cs_lvl) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            rd_phase <= 1'b0;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_sr <= {rx_sr[FRAME_W-2:0], copi_lvl};
            if (bit_cnt != CNT_W'(FRAME_W + 1)) bit_cnt <= bit_cnt + CNT_W'(1);
          end
          // The first data bit is already on cipo when loaded, so shifting starts one fall later
          if (!rd_phase && bit_cnt == CNT_W'(1 + ADDR_W) && rx_sr[ADDR_W] == RW_READ) begin
            tx_sr    <= mid_rd;
            rd_phase <= 1'b1;
          end else if (rd_phase && sclk_fall && bit_cnt > CNT_W'(1 + ADDR_W)) begin
            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
          end
          if (cs_rise) state <= COMMIT;
        end
        COMMIT: begin
          state    <= IDLE;
          rd_phase <= 1'b0;
          if (bit_cnt != CNT_W'(FRAME_W)) begin
            frame_err <= 1'b1;
          end else if (rx_sr[FRAME_W-1] == RW_WRITE) begin
            if (|end_hit) begin
              wr_stb <= end_hit;
              for (int i = 0; i < NUM_REGS; i++) begin
                if (end_hit[i]) regs[i*DATA_W +: DATA_W] <= rx_sr[DATA_W-1:0];
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cipo_oe = (state == SHIFT);
  assign cipo    = (state == SHIFT && rd_phase) ? tx_sr[DATA_W-1] : 1'b0;

endmodule
